// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state codes and the alignment rule for the load/store unit.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_RD   = 2'd1;
  localparam logic [1:0] LSU_WR   = 2'd2;
  localparam logic [1:0] LSU_RESP = 2'd3;

  // Size code 3 has no legal alignment, so it always reports misaligned.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      LSU_SZ_B: lsu_misaligned = 1'b0;
      LSU_SZ_H: lsu_misaligned = offset[0];
      LSU_SZ_W: lsu_misaligned = (offset != 2'b00);
      default:  lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath-side request/response bundle of the load/store unit.
interface load_store_unit_if #(parameter int AW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit_lane.sv
// Little-endian byte-lane logic: extracts and extends a load lane, and merges store data into a word.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] new_data,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shamt    = {offset, 3'b000};
  assign byte_sel = 8'(word >> shamt);
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ext_data = '0;
    merged   = word;
    case (size)
      LSU_SZ_B: begin
        ext_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged   = (word & ~(32'h0000_00FF << shamt)) | ({24'b0, new_data[7:0]} << shamt);
      end
      LSU_SZ_H: begin
        ext_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged   = offset[1] ? {new_data[15:0], word[15:0]} : {word[31:16], new_data[15:0]};
      end
      LSU_SZ_W: begin
        ext_data = word;
        merged   = new_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the datapath and a 1024-word memory with read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AW             = 32,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                clock,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_din,
  input  logic [31:0]         mem_dout
);

  logic [1:0]    state;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rbuf;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic          accept;
  logic          req_bad;
  logic [31:0]   lane_ext;
  logic [31:0]   lane_merged;

  assign bus.req_ready = reset && (state == LSU_IDLE);
  assign accept        = bus.req_valid && (state == LSU_IDLE);
  assign req_bad       = lsu_misaligned(bus.req_size, bus.req_addr[1:0])
                       || (|bus.req_addr[AW-1:MEM_WORDS_LOG2+2]);

  // Both lane paths operate on the word being read during RD.
  lsu_lane u_lane (
    .word        (mem_dout),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .new_data    (wdata_q),
    .ext_data    (lane_ext),
    .merged      (lane_merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= LSU_IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state)
        LSU_IDLE: if (accept) begin
          we_q    <= bus.req_we;
          size_q  <= bus.req_size;
          uns_q   <= bus.req_unsigned;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          if (req_bad) begin
            state        <= LSU_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (!bus.req_we || bus.req_size != LSU_SZ_W) begin
            state <= LSU_RD;
          end else begin
            state <= LSU_WR;
          end
        end
        LSU_RD: begin
          rbuf <= we_q ? lane_merged : mem_dout;
          if (we_q) begin
            state <= LSU_WR;
          end else begin
            state        <= LSU_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= lane_ext;
          end
        end
        LSU_WR: begin
          state        <= LSU_RESP;
          resp_valid_q <= 1'b1;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Strobes and address come from state alone, so reset removes them without a clock.
  assign mem_ren  = (state == LSU_RD);
  assign mem_wen  = (state == LSU_WR);
  assign mem_addr = (mem_ren || mem_wen) ? 32'(addr_q[AW-1:2]) : 32'h0;
  assign mem_din  = mem_wen ? ((size_q == LSU_SZ_W) ? wdata_q : rbuf) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases plus a random stream against a byte-level memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_clear;

  logic [31:0] mem_arr [1024];
  logic [7:0]  ref_bytes [4096];

  int tests_run;
  int tests_failed;
  int overlap_cnt;
  int bad_addr_cnt;

  load_store_unit_if #(.AW(32)) bus ();

  load_store_unit #(.AW(32), .MEM_WORDS_LOG2(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: combinational read, write committed at the negedge.
  assign mem_dout = mem_arr[mem_addr[9:0]];
  always @(negedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
    end else if (mem_wen) begin
      mem_arr[mem_addr[9:0]] <= mem_din;
    end
  end

  always @(negedge clock) begin
    if (mem_ren && mem_wen) overlap_cnt++;
    if ((mem_ren || mem_wen) && mem_addr[31:10] != 22'h0) bad_addr_cnt++;
    if (!mem_ren && !mem_wen && mem_addr != 32'h0) bad_addr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Reference: bytes, little-endian, computed straight from the access rules.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_data, output logic exp_err, output int exp_lat);
    int nb;
    logic [31:0] val;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || (addr[31:12] != 20'h0);
    exp_data = '0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (we) begin
      for (int k = 0; k < nb; k++) ref_bytes[int'(addr) + k] = wdata[8*k +: 8];
      exp_lat = (nb == 4) ? 2 : 3;
    end else begin
      val = '0;
      for (int k = 0; k < nb; k++) val = val | (32'(ref_bytes[int'(addr) + k]) << (8*k));
      if (nb < 4 && !uns && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      exp_data = val;
      exp_lat  = 2;
    end
  endtask

  task automatic wait_ready(output logic ok);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    ok = bus.req_ready;
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int strobes);
    logic ok;
    rdata = '0; err = 1'b0; lat = 99; strobes = 0;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
      strobes += int'(mem_ren) + int'(mem_wen);
      @(posedge clock); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_data, got_data;
    logic        exp_err, got_err;
    int          exp_lat, got_lat, got_strobes;
    model(we, size, uns, addr, wdata, exp_data, exp_err, exp_lat);
    do_req(we, size, uns, addr, wdata, got_data, got_err, got_lat, got_strobes);
    check({tag, "_data"},    got_data, exp_data);
    check({tag, "_err"},     32'(got_err), 32'(exp_err));
    check({tag, "_lat"},     32'(got_lat), 32'(exp_lat));
    check({tag, "_strobes"}, 32'(got_strobes), 32'(exp_lat - 1));
  endtask

  initial begin
    logic        ok;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    int          mism;

    tests_run = 0; tests_failed = 0; overlap_cnt = 0; bad_addr_cnt = 0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h00;

    // Reset held with a request pending: everything stays quiet.
    reset = 1'b0; mem_clear = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",      32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err",   32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_strobes",    32'({mem_ren, mem_wen}), 32'd0);
    check("rst_mem_addr",   mem_addr, 32'd0);
    check("rst_mem_din",    mem_din, 32'd0);
    @(negedge clock);
    mem_clear = 1'b0; bus.req_valid = 1'b0; reset = 1'b1;
    #1;
    check("rst_release_ready", 32'(bus.req_ready), 32'd1);

    // Word store then sign/zero-extended loads of its lanes.
    run_op("sw_40",  1'b1, 2'd2, 1'b0, 32'h40, 32'h8000_00F0);
    run_op("lbu_40", 1'b0, 2'd0, 1'b1, 32'h40, 32'h0);
    run_op("lb_40",  1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
    run_op("lh_42",  1'b0, 2'd1, 1'b0, 32'h42, 32'h0);

    // Sub-word store read-modify-write.
    run_op("sw_40b", 1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344);
    run_op("sb_41",  1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AB);
    check("sb_41_mem", mem_arr[16], 32'h1122_AB44);

    // Misaligned and out-of-range requests never strobe memory.
    run_op("sw_0",      1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_BABE);
    run_op("lw_42",     1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    run_op("sh_41",     1'b1, 2'd1, 1'b0, 32'h41, 32'h0000_5555);
    run_op("sz3",       1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    run_op("sw_1000",   1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678);
    check("sw_1000_mem", mem_arr[0], 32'hCAFE_BABE);

    // Reset dropped during the WR cycle of a byte store.
    wait_ready(ok);
    if (ok) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h55;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      @(posedge clock); #1;
      check("abort_wen_before", 32'(mem_wen), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_wen_async", 32'(mem_wen), 32'd0);
      check("abort_ready",     32'(bus.req_ready), 32'd0);
      @(negedge clock); #1;
      check("abort_mem_kept", mem_arr[16], ref_word(16));
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_idle_ready", 32'(bus.req_ready), 32'd1);
    end
    run_op("post_abort_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Random back-to-back stream over a small window.
    for (int n = 0; n < 300; n++) begin
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      wdata = $urandom;
      run_op("rnd", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, wdata);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem_arr[i] !== ref_word(i)) mism++;
    check("mem_image",     32'(mism), 32'd0);
    check("strobe_overlap", 32'(overlap_cnt), 32'd0);
    check("mem_addr_idle", 32'(bad_addr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
